// File: rtl/alu_bitops_pkg.sv
// Shared op codes, FSM state encoding and widths for the alu_bitops execution unit.
// The optional ALU_BITOPS_BARREL_EN build uses the same definitions.
package alu_bitops_pkg;

  localparam int ST_W = 2;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_SLL  = 3'b011,
    OP_SRL  = 3'b100,
    OP_SRA  = 3'b101,
    OP_RSV6 = 3'b110,
    OP_RSV7 = 3'b111
  } op_t;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_bitops_logic.sv
// Combinational AND/OR/XOR result mux; shift and reserved codes yield zero here.
module alu_bitops_logic
  import alu_bitops_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_bitops_mc.sv
// Multi-cycle bitwise/shift unit: logic ops finish in one cycle, shifts iterate SHIFT_STEP bits/cycle.
// Define ALU_BITOPS_BARREL_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_bitops_mc
  import alu_bitops_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] y,
  output logic            busy
);

  localparam int SHAMT_W = $clog2(XLEN);

  // Handshake: a request transfers on a clk edge where in_valid & in_ready; a result
  // transfers where out_valid & out_ready. in_ready is high only in IDLE, and y/out_valid
  // hold in DONE until the result transfers.

  state_t               state;
  logic [XLEN-1:0]      logic_y;
  logic [SHAMT_W-1:0]   shamt;
  logic                 is_shift;
  logic                 accept;

  alu_bitops_logic #(.XLEN(XLEN)) u_logic (
    .op (op),
    .a  (a),
    .b  (b),
    .y  (logic_y)
  );

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign shamt    = b[SHAMT_W-1:0];
  assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);

`ifdef ALU_BITOPS_BARREL_EN

  logic [XLEN-1:0] shift_y;

  always_comb begin
    shift_y = a;
    case (op)
      OP_SLL:  shift_y = a << shamt;
      OP_SRL:  shift_y = a >> shamt;
      OP_SRA:  shift_y = unsigned'($signed(a) >>> shamt);
      default: shift_y = a;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      y         <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            y         <= is_shift ? shift_y : logic_y;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

`else

  localparam logic [SHAMT_W-1:0] STEP_C = SHAMT_W'(SHIFT_STEP);

  logic [2:0]         op_q;
  logic [XLEN-1:0]    acc;
  logic [SHAMT_W-1:0] cnt;
  logic [SHAMT_W-1:0] step;
  logic [XLEN-1:0]    acc_nxt;

  // The final partial step is clipped so the total shift is exactly shamt.
  assign step = (cnt < STEP_C) ? cnt : STEP_C;

  always_comb begin
    acc_nxt = acc;
    case (op_q)
      OP_SLL:  acc_nxt = acc << step;
      OP_SRL:  acc_nxt = acc >> step;
      default: acc_nxt = unsigned'($signed(acc) >>> step);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      y         <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      op_q      <= OP_AND;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q <= op;
            busy <= 1'b1;
            if (is_shift && (shamt != '0)) begin
              acc   <= a;
              cnt   <= shamt;
              state <= ST_SHIFT;
            end else begin
              y         <= is_shift ? a : logic_y;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          acc <= acc_nxt;
          cnt <= cnt - step;
          if (cnt == step) begin
            y         <= acc_nxt;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_alu_bitops_mc.sv
// Directed plus randomized bench for alu_bitops_mc with a behavioural reference model.
// Honours ALU_BITOPS_BARREL_EN for the expected latency of shifts.
module tb_alu_bitops_mc;

  localparam int XLEN       = 32;
  localparam int SHIFT_STEP = 1;
  localparam int MAX_WAIT   = 200;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] y;
  logic            busy;

  int tests;
  int fails;
  logic [XLEN-1:0] exp_q[$];

  alu_bitops_mc #(.XLEN(XLEN), .SHIFT_STEP(SHIFT_STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Reference model, straight from the op definitions.
  function automatic logic [XLEN-1:0] model_y(input logic [2:0] o, input logic [XLEN-1:0] av,
                                               input logic [XLEN-1:0] bv);
    int sh;
    logic [XLEN-1:0] ones;
    sh   = int'(bv % XLEN);
    ones = '1;
    case (o)
      3'd0: return av & bv;
      3'd1: return av | bv;
      3'd2: return av ^ bv;
      3'd3: return av << sh;
      3'd4: return av >> sh;
      3'd5: return (av >> sh) | (av[XLEN-1] ? ~(ones >> sh) : '0);
      default: return '0;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [XLEN-1:0] bv);
    int sh;
    sh = int'(bv % XLEN);
`ifdef ALU_BITOPS_BARREL_EN
    return 1;
`else
    if ((o == 3'd3 || o == 3'd4 || o == 3'd5) && sh != 0)
      return 1 + (sh + SHIFT_STEP - 1) / SHIFT_STEP;
    return 1;
`endif
  endfunction

  // Driver: called #1 after a posedge with the unit idle. hold = cycles of out_ready low
  // once the result appears; new_req keeps another request pending during the hold.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [XLEN-1:0] av,
                        input logic [XLEN-1:0] bv, input int hold, input bit new_req);
    int lat;
    int exp_lat;
    logic [XLEN-1:0] expv;
    exp_q.push_back(model_y(o, av, bv));
    exp_lat = model_lat(o, bv);
    check({tag, "_in_ready_idle"}, XLEN'(in_ready), XLEN'(1));
    in_valid  = 1'b1;
    op        = o;
    a         = av;
    b         = bv;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    a         = $urandom;
    b         = $urandom;
    out_ready = (hold == 0);
    check({tag, "_busy"}, XLEN'(busy), XLEN'(1));
    check({tag, "_in_ready_low"}, XLEN'(in_ready), XLEN'(0));
    lat = 1;
    while (!out_valid && lat < MAX_WAIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    expv = exp_q.pop_front();
    check({tag, "_latency"}, XLEN'(lat), XLEN'(exp_lat));
    check({tag, "_y"}, y, expv);
    if (new_req) begin
      in_valid = 1'b1;
      op       = 3'd1;
      a        = 32'h1234_5678;
      b        = 32'h0000_0001;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, XLEN'(out_valid), XLEN'(1));
      check({tag, "_hold_y"}, y, expv);
      if (new_req) check({tag, "_hold_in_ready"}, XLEN'(in_ready), XLEN'(0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, "_post_valid"}, XLEN'(out_valid), XLEN'(0));
    check({tag, "_post_busy"}, XLEN'(busy), XLEN'(0));
    check({tag, "_post_in_ready"}, XLEN'(in_ready), XLEN'(1));
  endtask

  initial begin
    logic [2:0]      ro;
    logic [XLEN-1:0] ra;
    logic [XLEN-1:0] rb;
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 3'd0;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", XLEN'(out_valid), XLEN'(0));
    check("rst_y", y, '0);
    check("rst_busy", XLEN'(busy), XLEN'(0));
    check("rst_in_ready", XLEN'(in_ready), XLEN'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("and", 3'd0, 32'hFFFF_0000, 32'h0F0F_0F0F, 0, 1'b0);
    check("and_value", y, 32'h0F0F_0000);
    run_op("sra", 3'd5, 32'h8000_0000, 32'd5, 0, 1'b0);
    check("sra_value", y, 32'hFC00_0000);
    run_op("sll_mask", 3'd3, 32'h0000_0001, 32'h0000_0020, 0, 1'b0);
    check("sll_mask_value", y, 32'h0000_0001);
    run_op("srl", 3'd4, 32'hF000_0000, 32'd4, 0, 1'b0);
    check("srl_value", y, 32'h0F00_0000);
    run_op("xor_bp", 3'd2, 32'hAAAA_5555, 32'hFFFF_0000, 3, 1'b1);
    check("xor_bp_value", y, 32'h5555_5555);
    run_op("rsv7", 3'd7, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0, 1'b0);
    check("rsv7_value", y, 32'h0000_0000);
    run_op("srl31", 3'd4, 32'h8000_0000, 32'd31, 1, 1'b0);
    check("srl31_value", y, 32'h0000_0001);

    // Reset part-way through a long shift (or while a result is held).
    in_valid  = 1'b1;
    op        = 3'd4;
    a         = 32'hFFFF_FFFF;
    b         = 32'd31;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", XLEN'(out_valid), XLEN'(0));
    check("midrst_y", y, '0);
    check("midrst_busy", XLEN'(busy), XLEN'(0));
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("postrst_out_valid", XLEN'(out_valid), XLEN'(0));
    run_op("or", 3'd1, 32'h0000_0001, 32'h0000_0002, 0, 1'b0);
    check("or_value", y, 32'h0000_0003);

    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 1) == 1) ? $urandom : XLEN'($urandom_range(0, 40));
      run_op("rand", ro, ra, rb, $urandom_range(0, 2), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_bitops_mc.md
Name: alu_bitops_mc

Overview:
- Parametrised multi-cycle bitwise/shift execution unit for the RV32I datapath.
- Computes AND/OR/XOR (generalised fn_and family) and SLL/SRL/SRA on XLEN-bit operands.
- Uses a valid/ready handshake on both sides.
- Shifts run iteratively, SHIFT_STEP bits per cycle, to save area.

Parameters:
- XLEN, 32, operand/result width; power of two, >= 8.
- SHIFT_STEP, 1, bits shifted per cycle in iterative mode; power of two, 1..XLEN/2.
- SHAMT_W (localparam), $clog2(XLEN), shift-amount width; not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- op  in  3  000 AND, 001 OR, 010 XOR, 011 SLL, 100 SRL, 101 SRA, 110/111 reserved
- a  in  XLEN  operand A / shift source
- b  in  XLEN  operand B; shift amount = b[SHAMT_W-1:0]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- y  out  XLEN  result
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low, async) forces:
  - state=IDLE, y=0, out_valid=0, busy=0, internal counter=0.
  - in_ready is combinational (state==IDLE), so it reads 1 during reset.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - in_ready=1.
  - Accept occurs when in_valid & in_ready at a clk edge; op, a and b are registered.
  - Logic op or reserved op: y <= result (reserved gives 0), go to DONE.
  - Shift with shamt==0: y <= a, go to DONE.
  - Shift with shamt!=0: acc <= a, cnt <= shamt, go to SHIFT.
- SHIFT:
  - Each cycle: step = min(SHIFT_STEP, cnt); acc shifted by step; cnt -= step.
  - Fill rules: SLL fills with 0, SRL fills with 0, SRA fills with acc[XLEN-1].
  - When the step makes cnt reach 0: y <= shifted acc, go to DONE.
  - in_ready=0 throughout.
- DONE:
  - out_valid=1; y and out_valid are held stable until out_ready.
  - out_valid & out_ready at an edge: go to IDLE, out_valid drops next cycle.
  - No accept in DONE (no bypass). Throughput is at most one op per 2 cycles.
- Latency from accept edge to out_valid high:
  - 1 cycle for logic ops, reserved ops and shamt==0.
  - Otherwise 1 + ceil(shamt/SHIFT_STEP) cycles.
- The upper bits of b are ignored for shifts (RV32I semantics).
- Inputs are don't-care while in_ready=0; the unit never samples them then.
- Reset mid-SHIFT or mid-DONE abandons the operation; no result is emitted.
- out_ready asserted while out_valid=0 has no effect.

Optional Feature:
- Macro ALU_BITOPS_BARREL_EN.
- Defined:
  - A combinational barrel shifter computes shifts in the accept cycle, so all ops have latency 1.
  - SHIFT state and counter are not generated; SHIFT_STEP is ignored.
- Undefined: iterative shifting as above.
- The handshake and DONE behaviour are identical in both builds.

Decomposition:
- Package alu_bitops_pkg holds:
  - op codes (OP_AND..OP_SRA, OP_RSV6, OP_RSV7);
  - state enum (ST_IDLE, ST_SHIFT, ST_DONE);
  - the state width constant.
- Sub-module alu_bitops_logic: purely combinational AND/OR/XOR/reserved-zero result mux, XLEN parametrised, instantiated once.
- FSM, shifter and handshake stay in the top module.

Test Plan:
(All defaults: XLEN=32, SHIFT_STEP=1, out_ready=1 unless stated.)
- AND:
  - Stimulus: a=0xFFFF0000, b=0x0F0F0F0F.
  - Required: y=0x0F0F0000, out_valid high the cycle after accept, then IDLE, in_ready back to 1.
- SRA:
  - Stimulus: a=0x80000000, b=5.
  - Required: y=0xFC000000; out_valid rises 6 cycles after accept; in_ready=0 and busy=1 meanwhile.
- Masked shamt:
  - Stimulus: SLL a=0x00000001, b=0x00000020.
  - Required: shamt=0, y=0x00000001 with latency 1.
  - Then SRL a=0xF0000000, b=4 gives y=0x0F000000.
- Backpressure:
  - Stimulus: XOR a=0xAAAA5555, b=0xFFFF0000; hold out_ready=0 for 3 cycles; drive in_valid=1 with a new request.
  - Required: y=0x55555555 stable; in_ready=0; new request not accepted until after the handshake.
- Reset mid-op:
  - Stimulus: SRL a=0xFFFFFFFF, b=31; pull rst_n low 10 cycles in; release.
  - Required: out_valid=0, y=0, busy=0 immediately (async).
  - Then OR a=0x1, b=0x2 gives y=0x3.
- Reserved op and barrel build:
  - Reserved op=3'b111 gives y=0, latency 1.
  - With ALU_BITOPS_BARREL_EN, SRL a=0x80000000, b=31 gives y=0x00000001 with latency 1.
